apb4_master: RTL and testbench

APB4_MASTER -- requirements
Module: apb4_master

---
 rtl/apb4_master_pkg.sv | 21 ++
 rtl/apb4_if.sv | 29 ++
 rtl/apb4_master_tmo.sv | 44 ++++
 rtl/dffer.sv | 21 ++
 rtl/dffr.sv | 20 ++
 rtl/apb4_master.sv | 171 +++++++++++++++++
 tb/tb_apb4_master.sv | 261 ++++++++++++++++++++++++++
 7 files changed

// File: rtl/apb4_master_pkg.sv
// Shared APB4 master definitions: FSM encoding, APB field widths and default timeout.
// Pure declarations; no timing or flow control of its own.
package apb4_master_pkg;

  localparam int APB4_TIMEOUT_DEFAULT = 255;
  localparam int APB4_STATE_W         = 2;
  localparam int APB4_PROT_W          = 3;

  typedef enum logic [APB4_STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb4_state_e;

  // psel is asserted for the whole SETUP + ACCESS window.
  function automatic logic is_bus_active(apb4_state_e s);
    return (s == ST_SETUP) || (s == ST_ACCESS);
  endfunction

endpackage

// File: rtl/apb4_if.sv
// APB4 bus bundle between one master and one slave.
// No storage; the slave stalls the master by holding pready low.
interface apb4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]                paddr;
  logic [apb4_master_pkg::APB4_PROT_W-1:0] pprot;
  logic                                 psel;
  logic                                 penable;
  logic                                 pwrite;
  logic [DATA_WIDTH-1:0]                pwdata;
  logic [DATA_WIDTH/8-1:0]              pstrb;
  logic [DATA_WIDTH-1:0]                prdata;
  logic                                 pready;
  logic                                 pslverr;

  modport master (
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb4_master_tmo.sv
// ACCESS-phase watchdog: counts stalled ACCESS cycles, saturating, and flags expiry.
// expired is combinational in the cycle whose stall would make the count reach TIMEOUT.
module apb4_master_tmo
  import apb4_master_pkg::*;
#(
  parameter int TIMEOUT = APB4_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int SAT_I = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int LIM_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  localparam logic [CW-1:0] CNT_SAT = CW'(SAT_I);
  localparam logic [CW-1:0] CNT_LIM = CW'(LIM_I);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  dffr #(.W(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cnt_d),
    .q     (cnt_q)
  );

  // Firing one count early makes TIMEOUT equal the number of ACCESS cycles before abort.
  assign expired = (TIMEOUT != 0) && en && (cnt_q >= CNT_LIM);

endmodule

// File: rtl/dffer.sv
// Register library: D flop with load enable and asynchronous active-low clear to zero.
// One cycle latency; holds its value while en is low.
module dffer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dffr.sv
// Register library: D flop with asynchronous active-low clear to zero.
// One cycle latency, no enable.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/apb4_master.sv
// Single-outstanding APB4 master: request -> SETUP -> ACCESS (wait/timeout) -> held response.
// Four cycles minimum per transfer; a new request is taken only after the response is consumed.
module apb4_master
  import apb4_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = APB4_TIMEOUT_DEFAULT
) (
  input  logic                      pclk,
  input  logic                      presetn,

  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic                      req_write_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   req_strb_i,
  input  logic [APB4_PROT_W-1:0]    req_prot_i,

  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,

  apb4_if.master                    apb4
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [APB4_STATE_W-1:0] state_raw_q;
  apb4_state_e             state_q;
  apb4_state_e             state_d;

  logic                    live_q;
  logic                    accept;
  logic                    done;
  logic                    abort;
  logic                    tmo_expired;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    write_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [STRB_W-1:0]       strb_d;
  logic [STRB_W-1:0]       strb_q;
  logic [APB4_PROT_W-1:0]  prot_q;

  logic                    rsp_en;
  logic [DATA_WIDTH-1:0]   rdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_d;
  logic                    err_q;
  logic                    tmo_d;
  logic                    tmo_q;

  dffr #(.W(APB4_STATE_W)) u_state (
    .clk   (pclk),
    .rst_n (presetn),
    .d     (state_d),
    .q     (state_raw_q)
  );

  assign state_q = apb4_state_e'(state_raw_q);

  // Keeps req_ready_o low until the first clock edge after reset release.
  dffr #(.W(1)) u_live (
    .clk   (pclk),
    .rst_n (presetn),
    .d     (1'b1),
    .q     (live_q)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (live_q && req_valid_i) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb4.pready) begin
          done    = 1'b1;
          state_d = ST_RESP;
        end else if (tmo_expired) begin
          abort   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request payload is captured once at accept, so the APB fields cannot move mid-transfer.
  assign strb_d = req_write_i ? req_strb_i : '0;

  dffer #(.W(ADDR_WIDTH)) u_addr (
    .clk (pclk), .rst_n (presetn), .en (accept), .d (req_addr_i), .q (addr_q)
  );

  dffer #(.W(1)) u_write (
    .clk (pclk), .rst_n (presetn), .en (accept), .d (req_write_i), .q (write_q)
  );

  dffer #(.W(DATA_WIDTH)) u_wdata (
    .clk (pclk), .rst_n (presetn), .en (accept), .d (req_wdata_i), .q (wdata_q)
  );

  dffer #(.W(STRB_W)) u_strb (
    .clk (pclk), .rst_n (presetn), .en (accept), .d (strb_d), .q (strb_q)
  );

  dffer #(.W(APB4_PROT_W)) u_prot (
    .clk (pclk), .rst_n (presetn), .en (accept), .d (req_prot_i), .q (prot_q)
  );

  apb4_master_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (pclk),
    .rst_n   (presetn),
    .clr     (state_q == ST_SETUP),
    .en      ((state_q == ST_ACCESS) && !apb4.pready),
    .expired (tmo_expired)
  );

  assign rsp_en  = done || abort;
  assign rdata_d = (done && !write_q) ? apb4.prdata : '0;
  assign err_d   = done ? apb4.pslverr : 1'b1;
  assign tmo_d   = abort;

  dffer #(.W(DATA_WIDTH)) u_rdata (
    .clk (pclk), .rst_n (presetn), .en (rsp_en), .d (rdata_d), .q (rdata_q)
  );

  dffer #(.W(1)) u_err (
    .clk (pclk), .rst_n (presetn), .en (rsp_en), .d (err_d), .q (err_q)
  );

  dffer #(.W(1)) u_tmo_flag (
    .clk (pclk), .rst_n (presetn), .en (rsp_en), .d (tmo_d), .q (tmo_q)
  );

  assign req_ready_o   = live_q && (state_q == ST_IDLE);
  assign rsp_valid_o   = (state_q == ST_RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;

  assign apb4.psel    = is_bus_active(state_q);
  assign apb4.penable = (state_q == ST_ACCESS);
  assign apb4.paddr   = addr_q;
  assign apb4.pwrite  = write_q;
  assign apb4.pwdata  = wdata_q;
  assign apb4.pstrb   = strb_q;
  assign apb4.pprot   = prot_q;

endmodule

// File: tb/tb_apb4_master.sv
// Directed bench for apb4_master (TIMEOUT=4) with a configurable wait-state APB slave.
module tb_apb4_master;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          req_valid;
  logic          req_ready_o;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic [3:0]    req_strb;
  logic [2:0]    req_prot;
  logic          rsp_valid_o;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;

  int checks = 0;
  int errors = 0;

  int          sl_wait  = 0;
  logic        sl_hang  = 1'b0;
  logic        sl_err   = 1'b0;
  logic [31:0] sl_rdata = 32'h0;
  int          acc_cnt  = 0;

  always #5 pclk = ~pclk;

  apb4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb ();

  apb4_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .pclk          (pclk),
    .presetn       (presetn),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready_o),
    .req_addr_i    (req_addr),
    .req_write_i   (req_write),
    .req_wdata_i   (req_wdata),
    .req_strb_i    (req_strb),
    .req_prot_i    (req_prot),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready),
    .rsp_rdata_o   (rsp_rdata_o),
    .rsp_err_o     (rsp_err_o),
    .rsp_timeout_o (rsp_timeout_o),
    .apb4          (apb)
  );

  // Slave: ready after sl_wait stalled ACCESS cycles, never while sl_hang.
  assign apb.pready  = apb.psel && apb.penable && !sl_hang && (acc_cnt >= sl_wait);
  assign apb.prdata  = sl_rdata;
  assign apb.pslverr = sl_err && apb.pready;

  always @(posedge pclk) begin
    if (apb.psel && apb.penable && !apb.pready) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p);
    int n = 0;
    while (!req_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready_o) begin
      checks++; errors++;
      $display("FAIL issue_wait_ready got %0b want 1", req_ready_o);
    end
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d; req_strb = s; req_prot = p;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int acc);
    int n = 0;
    acc = 0;
    while (!rsp_valid_o && n < 40) begin
      if (apb.psel && apb.penable) acc++;
      tick();
      n++;
    end
    if (!rsp_valid_o) begin
      checks++; errors++;
      $display("FAIL wait_rsp_timeout got %0b want 1", rsp_valid_o);
    end
  endtask

  task automatic drain();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b1;
    #1 presetn = 1'b0;
    #1;
    checks++; if (apb.psel !== 1'b0) begin errors++; $display("FAIL rst_psel got %0b want 0", apb.psel); end
    checks++; if (apb.penable !== 1'b0) begin errors++; $display("FAIL rst_penable got %0b want 0", apb.penable); end
    checks++; if (apb.paddr !== 32'h0) begin errors++; $display("FAIL rst_paddr got %h want 0", apb.paddr); end
    checks++; if (rsp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid_o); end
    checks++; if ({rsp_err_o, rsp_timeout_o} !== 2'b00) begin errors++; $display("FAIL rst_rsp_flags got %b want 00", {rsp_err_o, rsp_timeout_o}); end
    checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h want 0", rsp_rdata_o); end
    tick();
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b want 0", req_ready_o); end
    presetn = 1'b1;
    #1;
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL rel_req_ready_pre_edge got %0b want 0", req_ready_o); end
    tick();
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rel_req_ready_post_edge got %0b want 1", req_ready_o); end
  endtask

  task automatic test_write();
    sl_wait = 0; sl_err = 1'b0; sl_hang = 1'b0;
    issue(32'h0000_0008, 1'b1, 32'hA5A5_5A5A, 4'hF, 3'b010);
    checks++; if ({apb.psel, apb.penable} !== 2'b10) begin errors++; $display("FAIL wr_setup_sel_en got %b want 10", {apb.psel, apb.penable}); end
    checks++; if (apb.paddr !== 32'h8) begin errors++; $display("FAIL wr_paddr got %h want 00000008", apb.paddr); end
    checks++; if (apb.pwdata !== 32'hA5A5_5A5A) begin errors++; $display("FAIL wr_pwdata got %h want a5a55a5a", apb.pwdata); end
    checks++; if ({apb.pwrite, apb.pstrb, apb.pprot} !== 8'b1_1111_010) begin errors++; $display("FAIL wr_ctl got %b want 11111010", {apb.pwrite, apb.pstrb, apb.pprot}); end
    checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL wr_setup_req_ready got %0b want 0", req_ready_o); end
    tick();
    checks++; if ({apb.psel, apb.penable, rsp_valid_o} !== 3'b110) begin errors++; $display("FAIL wr_access got %b want 110", {apb.psel, apb.penable, rsp_valid_o}); end
    tick();
    checks++; if ({rsp_valid_o, apb.psel, apb.penable} !== 3'b100) begin errors++; $display("FAIL wr_cycle4_resp got %b want 100", {rsp_valid_o, apb.psel, apb.penable}); end
    checks++; if ({rsp_err_o, rsp_timeout_o} !== 2'b00) begin errors++; $display("FAIL wr_rsp_flags got %b want 00", {rsp_err_o, rsp_timeout_o}); end
    checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL wr_rsp_rdata got %h want 0", rsp_rdata_o); end
    drain();
    checks++; if ({rsp_valid_o, req_ready_o} !== 2'b01) begin errors++; $display("FAIL wr_back_idle got %b want 01", {rsp_valid_o, req_ready_o}); end
  endtask

  task automatic test_read_wait();
    int  acc = 0;
    int  n = 0;
    bit  strb_bad = 1'b0;
    bit  addr_bad = 1'b0;
    sl_wait = 3; sl_rdata = 32'h1234_5678;
    issue(32'h0000_0004, 1'b0, 32'hFFFF_FFFF, 4'hF, 3'b000);
    while (!rsp_valid_o && n < 40) begin
      if (apb.psel && (apb.pstrb !== 4'h0)) strb_bad = 1'b1;
      if (apb.psel && (apb.paddr !== 32'h4 || apb.pwrite !== 1'b0)) addr_bad = 1'b1;
      if (apb.psel && apb.penable) acc++;
      tick();
      n++;
    end
    checks++; if (rsp_valid_o !== 1'b1) begin errors++; $display("FAIL rd_rsp_valid got %0b want 1", rsp_valid_o); end
    checks++; if (acc != 4) begin errors++; $display("FAIL rd_access_cycles got %0d want 4", acc); end
    checks++; if (rsp_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata got %h want 12345678", rsp_rdata_o); end
    checks++; if ({rsp_err_o, rsp_timeout_o} !== 2'b00) begin errors++; $display("FAIL rd_flags_at_limit got %b want 00", {rsp_err_o, rsp_timeout_o}); end
    checks++; if (strb_bad) begin errors++; $display("FAIL rd_pstrb_nonzero got 1 want 0"); end
    checks++; if (addr_bad) begin errors++; $display("FAIL rd_addr_unstable got 1 want 0"); end
    drain();
  endtask

  task automatic test_slverr();
    int acc;
    sl_wait = 1; sl_err = 1'b1; sl_rdata = 32'h5555_AAAA;
    issue(32'h0000_0010, 1'b1, 32'h0BAD_F00D, 4'h5, 3'b001);
    wait_rsp(acc);
    checks++; if (acc != 2) begin errors++; $display("FAIL err_access_cycles got %0d want 2", acc); end
    checks++; if ({rsp_err_o, rsp_timeout_o} !== 2'b10) begin errors++; $display("FAIL err_flags got %b want 10", {rsp_err_o, rsp_timeout_o}); end
    checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL err_rdata got %h want 0", rsp_rdata_o); end
    drain();
    sl_err = 1'b0;
  endtask

  task automatic test_timeout();
    int acc;
    sl_wait = 0; sl_hang = 1'b1; sl_rdata = 32'hDEAD_BEEF;
    issue(32'h0000_0020, 1'b0, 32'h0, 4'h0, 3'b000);
    wait_rsp(acc);
    checks++; if (acc != 4) begin errors++; $display("FAIL tmo_access_cycles got %0d want 4", acc); end
    checks++; if ({rsp_err_o, rsp_timeout_o} !== 2'b11) begin errors++; $display("FAIL tmo_flags got %b want 11", {rsp_err_o, rsp_timeout_o}); end
    checks++; if (rsp_rdata_o !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h want 0", rsp_rdata_o); end
    checks++; if ({apb.psel, apb.penable} !== 2'b00) begin errors++; $display("FAIL tmo_resp_psel got %b want 00", {apb.psel, apb.penable}); end
    drain();
    sl_hang = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc;
    sl_wait = 0; sl_rdata = 32'hCAFE_0001;
    issue(32'h0000_0030, 1'b0, 32'h0, 4'hF, 3'b100);
    wait_rsp(acc);
    sl_rdata = 32'h0;
    req_valid = 1'b1; req_addr = 32'h34; req_write = 1'b1; req_wdata = 32'h1122_3344; req_strb = 4'h3; req_prot = 3'b000;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({req_ready_o, rsp_valid_o} !== 2'b01) begin errors++; $display("FAIL b2b_hold_%0d got %b want 01", i, {req_ready_o, rsp_valid_o}); end
      checks++; if (rsp_rdata_o !== 32'hCAFE_0001) begin errors++; $display("FAIL b2b_rdata_%0d got %h want cafe0001", i, rsp_rdata_o); end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++; if ({req_ready_o, rsp_valid_o} !== 2'b10) begin errors++; $display("FAIL b2b_idle got %b want 10", {req_ready_o, rsp_valid_o}); end
    tick();
    req_valid = 1'b0;
    checks++; if ({apb.psel, apb.penable} !== 2'b10) begin errors++; $display("FAIL b2b_next_setup got %b want 10", {apb.psel, apb.penable}); end
    checks++; if ({apb.paddr, apb.pstrb} !== {32'h34, 4'h3}) begin errors++; $display("FAIL b2b_next_fields got %h want 000000343", {apb.paddr, apb.pstrb}); end
    wait_rsp(acc);
    checks++; if ({rsp_err_o, rsp_rdata_o} !== 33'h0) begin errors++; $display("FAIL b2b_next_rsp got %h want 0", {rsp_err_o, rsp_rdata_o}); end
    drain();
  endtask

  task automatic test_reset_mid();
    bit saw_rsp = 1'b0;
    bit saw_sel = 1'b0;
    sl_hang = 1'b1;
    issue(32'h0000_0040, 1'b1, 32'h7777_7777, 4'hF, 3'b011);
    tick();
    tick();
    checks++; if ({apb.psel, apb.penable} !== 2'b11) begin errors++; $display("FAIL rmid_in_access got %b want 11", {apb.psel, apb.penable}); end
    #2 presetn = 1'b0;
    #1;
    checks++; if ({apb.psel, apb.penable, apb.pwrite} !== 3'b000) begin errors++; $display("FAIL rmid_async_ctl got %b want 000", {apb.psel, apb.penable, apb.pwrite}); end
    checks++; if ({apb.paddr, apb.pwdata} !== 64'h0) begin errors++; $display("FAIL rmid_async_payload got %h want 0", {apb.paddr, apb.pwdata}); end
    checks++; if ({req_ready_o, rsp_valid_o} !== 2'b00) begin errors++; $display("FAIL rmid_async_hs got %b want 00", {req_ready_o, rsp_valid_o}); end
    sl_hang = 1'b0;
    @(posedge pclk);
    #3 presetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid_o) saw_rsp = 1'b1;
      if (apb.psel) saw_sel = 1'b1;
    end
    checks++; if (saw_rsp) begin errors++; $display("FAIL rmid_stray_rsp got 1 want 0"); end
    checks++; if (saw_sel) begin errors++; $display("FAIL rmid_stray_psel got 1 want 0"); end
    checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL rmid_ready_after got %0b want 1", req_ready_o); end
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0; req_strb = '0; req_prot = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_write();
    test_read_wait();
    test_slverr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit got running want finished");
    $fatal(1, "time limit");
  end

endmodule
